// File: rtl/seg7_scan_ndigit.sv
// -----------------------------------------------------------------------------
// seg7_scan_ndigit
//   Time-multiplexed driver for NDIG common-anode style 7-segment digits.
//   Each digit is driven for SCAN_DIV clocks in turn (digit 0 first). The
//   display inputs are sampled once per frame, at the first slot of digit 0,
//   so a frame never shows a mix of old and new data. Supports per-digit
//   decimal points, per-digit blinking (BLINK_FRAMES frames on / off) and
//   leading-zero blanking.
//
// Ports
//   clk_i          system clock, all state on rising edge
//   reset_i        synchronous active-high reset
//   enable_i       1 = display active, 0 = all digits dark (scan keeps running)
//   value_i        NDIG hex nibbles, digit i = value_i[4*i+3:4*i], digit 0 rightmost
//   dp_in_i        per-digit decimal point request, 1 = lit
//   blink_mask_i   per-digit blink enable
//   blank_lz_i     leading-zero blanking enable
//   seg_o          {g,f,e,d,c,b,a}, active-low, registered
//   dp_o           decimal point, active-low, registered
//   an_o           digit select, active-low, registered
//   frame_tick_o   one-cycle pulse on the cycle after the digit index wraps to 0
// -----------------------------------------------------------------------------
module seg7_scan_ndigit #(
    parameter int NDIG         = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              enable_i,
    input  logic [NDIG*4-1:0] value_i,
    input  logic [NDIG-1:0]   dp_in_i,
    input  logic [NDIG-1:0]   blink_mask_i,
    input  logic              blank_lz_i,
    output logic [6:0]        seg_o,
    output logic              dp_o,
    output logic [NDIG-1:0]   an_o,
    output logic              frame_tick_o
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0] DIG_LAST   = DW'(NDIG - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    function automatic logic [6:0] hex2seg(input logic [3:0] n);
        case (n)
            4'h0:    hex2seg = 7'b1000000;
            4'h1:    hex2seg = 7'b1111001;
            4'h2:    hex2seg = 7'b0100100;
            4'h3:    hex2seg = 7'b0110000;
            4'h4:    hex2seg = 7'b0011001;
            4'h5:    hex2seg = 7'b0010010;
            4'h6:    hex2seg = 7'b0000010;
            4'h7:    hex2seg = 7'b1111000;
            4'h8:    hex2seg = 7'b0000000;
            4'h9:    hex2seg = 7'b0010000;
            4'hA:    hex2seg = 7'b0001000;
            4'hB:    hex2seg = 7'b0000011;
            4'hC:    hex2seg = 7'b1000110;
            4'hD:    hex2seg = 7'b0100001;
            4'hE:    hex2seg = 7'b0000110;
            default: hex2seg = 7'b0001110;
        endcase
    endfunction

    // Scan / blink state
    logic [SW-1:0]     scan_cnt_q,   scan_cnt_d;
    logic [DW-1:0]     digit_idx_q,  digit_idx_d;
    logic [FW-1:0]     frame_cnt_q,  frame_cnt_d;
    logic              blink_ph_q,   blink_ph_d;

    // Per-frame captured display inputs
    logic [NDIG*4-1:0] value_q,      value_d;
    logic [NDIG-1:0]   dp_q,         dp_d;
    logic [NDIG-1:0]   blink_q,      blink_d;
    logic              blz_q,        blz_d;

    // Output registers
    logic [6:0]        seg_q,        seg_d;
    logic              dp_out_q,     dp_out_d;
    logic [NDIG-1:0]   an_q,         an_d;
    logic              ftick_q,      ftick_d;

    logic              scan_last, digit_last, frame_wrap, capture;
    logic [NDIG-1:0]   lz_blank;
    logic              upper_zero;
    logic [3:0]        cur_nib;
    logic              cur_dp, cur_blank;

    always_comb begin
        scan_last  = (scan_cnt_q == SCAN_LAST);
        digit_last = (digit_idx_q == DIG_LAST);
        frame_wrap = scan_last && digit_last;
        capture    = (scan_cnt_q == '0) && (digit_idx_q == '0);

        scan_cnt_d  = scan_last ? '0 : scan_cnt_q + 1'b1;
        digit_idx_d = digit_idx_q;
        if (scan_last)
            digit_idx_d = digit_last ? '0 : digit_idx_q + 1'b1;

        frame_cnt_d = frame_cnt_q;
        blink_ph_d  = blink_ph_q;
        if (frame_wrap) begin
            if (frame_cnt_q == FRAME_LAST) begin
                frame_cnt_d = '0;
                blink_ph_d  = ~blink_ph_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end

        // The slot that captures also displays the freshly captured data, so
        // digit 0 of a new frame never shows the previous frame's nibble.
        value_d = capture ? value_i      : value_q;
        dp_d    = capture ? dp_in_i      : dp_q;
        blink_d = capture ? blink_mask_i : blink_q;
        blz_d   = capture ? blank_lz_i   : blz_q;

        // Walk from the most significant digit down: a digit is a leading
        // zero while every nibble from it upward is zero. Digit 0 is exempt.
        lz_blank   = '0;
        upper_zero = 1'b1;
        for (int i = NDIG - 1; i >= 1; i--) begin
            upper_zero  = upper_zero && (value_d[4*i +: 4] == 4'h0);
            lz_blank[i] = blz_d && upper_zero;
        end

        cur_nib   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (digit_idx_q == DW'(i)) begin
                cur_nib   = value_d[4*i +: 4];
                cur_dp    = dp_d[i];
                cur_blank = lz_blank[i] || (blink_d[i] && blink_ph_q);
            end
        end

        // Blanked digits keep their anode low so brightness stays uniform.
        if (enable_i) begin
            an_d     = ~(NDIG'(1) << digit_idx_q);
            seg_d    = cur_blank ? SEG_OFF : hex2seg(cur_nib);
            dp_out_d = cur_blank ? 1'b1 : ~cur_dp;
        end else begin
            an_d     = '1;
            seg_d    = SEG_OFF;
            dp_out_d = 1'b1;
        end

        ftick_d = frame_wrap;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            scan_cnt_q  <= '0;
            digit_idx_q <= '0;
            frame_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
            value_q     <= '0;
            dp_q        <= '0;
            blink_q     <= '0;
            blz_q       <= 1'b0;
            seg_q       <= SEG_OFF;
            dp_out_q    <= 1'b1;
            an_q        <= '1;
            ftick_q     <= 1'b0;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            digit_idx_q <= digit_idx_d;
            frame_cnt_q <= frame_cnt_d;
            blink_ph_q  <= blink_ph_d;
            value_q     <= value_d;
            dp_q        <= dp_d;
            blink_q     <= blink_d;
            blz_q       <= blz_d;
            seg_q       <= seg_d;
            dp_out_q    <= dp_out_d;
            an_q        <= an_d;
            ftick_q     <= ftick_d;
        end
    end

    assign seg_o        = seg_q;
    assign dp_o         = dp_out_q;
    assign an_o         = an_q;
    assign frame_tick_o = ftick_q;

endmodule
